// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a retired-instruction counter.
// Controls are combinational from state/opcode; define MEM_WAIT_EN to stall FETCH and MEMORY until mem_ready.
module multicycle_control #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [10:0]            instruction_part,
   input  logic                   zero_alu,
   input  logic                   mem_ready,
   output logic                   pc_write,
   output logic                   ir_write,
   output logic                   i_or_d,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   reg_write,
   output logic                   mem_to_reg,
   output logic                   reg_to_loc,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             alu_op,
   output logic                   pc_source,
   output logic                   illegal,
   output logic [2:0]             current_state,
   output logic [COUNT_WIDTH-1:0] instr_retired
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_ILL, C_RTYPE, C_LDUR, C_STUR, C_CBZ
   } cls_t;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] count_q;
   cls_t                   cls;
   logic                   mem_done;
   logic                   retire;
   logic                   pc_write_raw, ir_write_raw, mem_read_raw;
   logic                   mem_write_raw, reg_write_raw, illegal_raw;

`ifdef MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign mem_done         = 1'b1;
`endif

   always_comb begin
      cls = C_ILL;
      casez (instruction_part)
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: cls = C_RTYPE;
         11'b11111000010: cls = C_LDUR;
         11'b11111000000: cls = C_STUR;
         11'b10110100???: cls = C_CBZ;
         default:         cls = C_ILL;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_read_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      i_or_d        = 1'b0;
      mem_to_reg    = 1'b0;
      reg_to_loc    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_raw = 1'b1;
            alu_src_b    = 2'b01;
            if (mem_done) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_d      = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is formed here so EXECUTE can load it for CBZ.
            alu_src_b = 2'b11;
            if (cls == C_ILL) begin
               illegal_raw = 1'b1;
               state_d     = S_FETCH;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            case (cls)
               C_RTYPE: begin
                  alu_src_a = 1'b1;
                  alu_op    = 2'b10;
                  state_d   = S_WRITEBACK;
               end
               C_LDUR, C_STUR: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
                  state_d   = S_MEMORY;
               end
               C_CBZ: begin
                  reg_to_loc   = 1'b1;
                  alu_op       = 2'b01;
                  pc_source    = 1'b1;
                  pc_write_raw = zero_alu;
                  retire       = 1'b1;
                  state_d      = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMORY: begin
            i_or_d = 1'b1;
            case (cls)
               C_LDUR: begin
                  mem_read_raw = 1'b1;
                  if (mem_done) state_d = S_WRITEBACK;
               end
               C_STUR: begin
                  reg_to_loc    = 1'b1;
                  mem_write_raw = 1'b1;
                  if (mem_done) begin
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_WRITEBACK: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = (cls == C_LDUR);
            retire        = 1'b1;
            state_d       = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Side-effecting strobes are held off while reset is low.
   assign pc_write      = pc_write_raw  & reset;
   assign ir_write      = ir_write_raw  & reset;
   assign mem_read      = mem_read_raw  & reset;
   assign mem_write     = mem_write_raw & reset;
   assign reg_write     = reg_write_raw & reset;
   assign illegal       = illegal_raw   & reset;
   assign current_state = state_q;
   assign instr_retired = count_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) count_q <= count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the LEGv8 datapath. It replaces the single-cycle combinational control and lets one shared memory port and one ALU serve each instruction over several clocks. It decodes the latched instruction opcode and steps a FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. Each cycle it drives the datapath enables and multiplexer selects, and it counts retired instructions.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- instruction_part  input  11  opcode field instruction[31:21] from instruction register
- zero_alu  input  1  ALU zero flag
- mem_ready  input  1  memory access complete (used only with MEM_WAIT_EN)
- pc_write  output  1  PC register load
- ir_write  output  1  instruction register load
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- reg_write  output  1  register bank write
- mem_to_reg  output  1  write-back select: 0 = ALU result, 1 = memory data
- reg_to_loc  output  1  read port 2 select: 0 = instr[20:16], 1 = instr[4:0]
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extend, 11 = sign-extend << 2
- alu_op  output  2  to ALUControl: 00 add, 01 pass-B/zero test, 10 R-type funct
- pc_source  output  1  0 = ALU output, 1 = branch target register
- illegal  output  1  one-cycle pulse on undecodable opcode
- current_state  output  3  FSM state, debug
- instr_retired  output  COUNT_WIDTH  retired-instruction count

## Operation
- Opcode classes:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - LDUR: 11111000010
  - STUR: 11111000000
  - CBZ: 10110100xxx
  - Anything else is illegal.
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4. Encodings 5–7 go to FETCH on the next edge.
- FETCH:
  - Drives i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write and pc_write are asserted in the completing cycle.
  - Next state: DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00, so the branch target is computed.
  - Classifies the opcode.
  - If illegal: pulse illegal, go to FETCH, and do not count the instruction.
  - Otherwise: go to EXECUTE.
- EXECUTE, by class:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op=10, then WRITEBACK.
  - LDUR/STUR: alu_src_a=1, alu_src_b=10, alu_op=00, then MEMORY.
  - CBZ: reg_to_loc=1, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero_alu. Retire, then FETCH.
- MEMORY:
  - Always i_or_d=1.
  - LDUR: mem_read=1, then WRITEBACK.
  - STUR: reg_to_loc=1 and mem_write=1. Retires in the completing cycle, then FETCH.
- WRITEBACK:
  - reg_write=1; mem_to_reg=1 for LDUR, 0 for R-type.
  - Retire, then FETCH.
- All outputs not listed for a state are 0.
- instr_retired increments by 1 at each retire and wraps from all-ones to 0.

## Timing
- Outputs are combinational from current state, opcode, zero_alu and mem_ready. State and counter are registered.
- Reset:
  - Any rising edge with reset=0 sets state=FETCH and instr_retired=0, regardless of current state (aborts mid-instruction).
  - While reset=0, pc_write, ir_write, mem_read, mem_write, reg_write and illegal are forced to 0.
  - The first fetch occurs in the first cycle with reset=1.
- Latency with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, illegal 2.
- The retire increment is visible on instr_retired the cycle after the retiring cycle.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH and MEMORY are complete only in a cycle with mem_ready=1. Otherwise the FSM holds its state and keeps the strobes asserted, with ir_write=pc_write=0 (FETCH) and no retire (STUR).
  - Each wait cycle adds one cycle of latency.
- MEM_WAIT_EN undefined: mem_ready is ignored; FETCH and MEMORY always complete in one cycle.

## Test plan
- Reset low 3 cycles, then high; opcode=ADD (10001011000) repeatedly -> current_state 0,1,2,4,0 and reg_write=1 only in state 4; instr_retired=3 after 12 cycles.
- LDUR (11111000010) -> states 0,1,2,3,4; mem_read=1, i_or_d=1 in state 3; mem_to_reg=1, reg_write=1 in state 4.
- CBZ with zero_alu=1 -> pc_write=1, pc_source=1 in EXECUTE; with zero_alu=0 -> pc_write=0; both return to FETCH after 3 cycles and both retire.
- Opcode 00000000000 -> illegal pulses once in DECODE, FETCH next, instr_retired unchanged.
- MEM_WAIT_EN with STUR and mem_ready low 2 cycles in MEMORY -> mem_write held 3 cycles, FSM stays in 3, retire only on the ready cycle.
- reset driven low during MEMORY of LDUR -> next state FETCH, counter 0, no reg_write issued.
